// File: rtl/opcode_data_tx.sv
// Serial transmitter for opcode/data pairs: start, opcode (LSB first), data (LSB first),
// optional even-parity bit, stop. Define TX_PARITY_EN to include the parity bit.
module opcode_data_tx #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] opcode,
    input  logic [7:0] data,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_OPCODE = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd5;
`endif

    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    op_q, dat_q;
`ifdef TX_PARITY_EN
    logic          par_q;
`endif
    logic          handshake;
    logic          last;
    logic          line_n;

    assign handshake = in_valid && in_ready;
    assign last      = (cnt == LAST);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        if (state == ST_IDLE) begin
            if (handshake) begin
                state_n = ST_START;
                cnt_n   = '0;
                bit_n   = '0;
            end
        end else if (!last) begin
            cnt_n = cnt + CW'(1);
        end else begin
            cnt_n = '0;
            case (state)
                ST_START:  state_n = ST_OPCODE;
                ST_OPCODE: begin
                    bit_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = ST_DATA;
                end
                ST_DATA: begin
                    bit_n = bit_idx + 3'd1;
`ifdef TX_PARITY_EN
                    if (bit_idx == 3'd7) state_n = ST_PARITY;
`else
                    if (bit_idx == 3'd7) state_n = ST_STOP;
`endif
                end
`ifdef TX_PARITY_EN
                ST_PARITY: state_n = ST_STOP;
`endif
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    // Line level is computed from the upcoming state so every output stays a flop.
    always_comb begin
        line_n = 1'b1;
        case (state_n)
            ST_START:  line_n = 1'b0;
            ST_OPCODE: line_n = op_q[bit_n];
            ST_DATA:   line_n = dat_q[bit_n];
`ifdef TX_PARITY_EN
            ST_PARITY: line_n = par_q;
`endif
            default:   line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            op_q       <= '0;
            dat_q      <= '0;
`ifdef TX_PARITY_EN
            par_q      <= 1'b0;
`endif
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
            in_ready   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            if (handshake) begin
                op_q  <= opcode;
                dat_q <= data;
`ifdef TX_PARITY_EN
                par_q <= ^data;
`endif
            end
            tx_serial  <= line_n;
            tx_busy    <= (state_n != ST_IDLE);
            in_ready   <= (state_n == ST_IDLE);
            frame_done <= (state_n == ST_STOP) && (cnt_n == LAST);
        end
    end

endmodule

// File: tb/tb_opcode_data_tx.sv
// Randomized bench for opcode_data_tx: two instances (BIT_CYCLES 4 and 1) share inputs;
// a frame-level bit-list model predicts the line cycle by cycle for the selected one.
module tb_opcode_data_tx;

`ifdef TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] opcode = 8'h00;
    logic [7:0] data = 8'h00;

    logic rdy4, ser4, busy4, done4;
    logic rdy1, ser1, busy1, done1;
    logic sel = 1'b0;
    int   bc;

    logic rdy, ser, busy, done;
    assign rdy  = sel ? rdy1  : rdy4;
    assign ser  = sel ? ser1  : ser4;
    assign busy = sel ? busy1 : busy4;
    assign done = sel ? done1 : done4;
    assign bc   = sel ? 1 : 4;

    int tests = 0;
    int fails = 0;

    opcode_data_tx #(.BIT_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy4),
        .opcode(opcode), .data(data), .tx_serial(ser4), .tx_busy(busy4), .frame_done(done4)
    );

    opcode_data_tx #(.BIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .opcode(opcode), .data(data), .tx_serial(ser1), .tx_busy(busy1), .frame_done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (bc=%0d t=%0t)", tag, got, exp, bc, $time);
        end
    endtask

    // Frame as a list of line levels, one per bit; cycle k (1-based) shows bit (k-1)/bc.
    function automatic logic exp_line(input logic [7:0] op, input logic [7:0] dat,
                                      input int k, input int cyc);
        logic bits[$];
        int   idx;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(op[i]);
        for (int i = 0; i < 8; i++) bits.push_back(dat[i]);
        if (PAR) bits.push_back(^dat);
        bits.push_back(1'b1);
        idx = (k - 1) / cyc;
        return (idx < bits.size()) ? bits[idx] : 1'b1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_ser"},  ser,  1);
        chk({tag, "_rdy"},  rdy,  1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Called #1 after an edge; handshake happens at the end of the current cycle.
    task automatic run_frame(input logic [7:0] op, input logic [7:0] dat,
                             input int abort_k, input bit noise);
        int fl;
        fl = (PAR ? 19 : 18) * bc;
        chk("hs_ready", rdy, 1);
        in_valid = 1'b1;
        opcode   = op;
        data     = dat;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= fl; k++) begin
            chk($sformatf("line_k%0d", k), ser, exp_line(op, dat, k, bc));
            chk("busy", busy, 1);
            chk("ready", rdy, 0);
            chk($sformatf("done_k%0d", k), done, (k == fl));
            if (k == abort_k) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk_idle("after_abort");
                return;
            end
            if (noise) begin
                in_valid = 1'b1;
                opcode   = 8'($urandom);
                data     = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        chk_idle("post_frame");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic suite();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk_idle("reset_idle");
            @(posedge clk); #1;
        end
        run_frame(8'h10, 8'hAA, -1, 1'b0);
        run_frame(8'hFF, 8'h01, -1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_frame(8'($urandom), 8'($urandom), -1, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end
        // Busy ignore: inputs toggle during the frame, next frame starts in the first idle cycle.
        run_frame(8'($urandom), 8'($urandom), -1, 1'b1);
        run_frame(8'h5A, 8'hC3, -1, 1'b0);
        // Abort during data bit 3 (bit index 12 of the frame).
        run_frame(8'($urandom), 8'($urandom), 12 * bc + 1, 1'b0);
        run_frame(8'h81, 8'h7E, -1, 1'b0);
        // Reset wins over a simultaneous in_valid.
        reset = 1'b1;
        in_valid = 1'b1;
        opcode = 8'h33;
        data = 8'h44;
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        chk_idle("reset_vs_valid");
        @(posedge clk); #1;
        chk_idle("reset_vs_valid2");
    endtask

    initial begin
        sel = 1'b0;
        suite();
        sel = 1'b1;
        suite();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
